// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port: valid/ready request channel plus valid-only response channel.
interface mem_stage_lsu_if #(
    parameter int DMEM_ADDR_W = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [DMEM_ADDR_W-1:0] req_addr;
    logic [31:0]            req_wdata;
    logic [3:0]             req_wstrb;
    logic                   rsp_valid;
    logic [31:0]            rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, sign/zero extension for loads, and
// access legality (funct3 and natural alignment) checking.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        fault,
    output logic [31:0] load_data
);

    logic [3:0][7:0] lane_bytes;
    logic [31:0]     shifted;
    logic            legal;
    logic            misaligned;

    // Each byte lane carries the store byte that would land there for this size.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_bytes[gi] = (funct3[1:0] == 2'b00) ? store_data[7:0] :
                                (funct3[1:0] == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                         store_data[8*gi +: 8];
    end
    assign wdata = lane_bytes;

    // Strobes follow the access size, shifted to the byte offset.
    always_comb begin
        case (funct3[1:0])
            2'b00:   wstrb = 4'b0001 << offset;
            2'b01:   wstrb = 4'b0011 << offset;
            default: wstrb = 4'b1111;
        endcase
    end

    // Illegal size encodings or unnaturally aligned halfword/word accesses fault.
    always_comb begin
        if (is_store)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        fault = !legal || misaligned;
    end

    assign shifted = rdata >> {offset, 3'b000};

    // Extract the addressed byte/halfword and extend to 32 bits.
    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: issues loads/stores on the data-memory port, stalls
// the pipeline while a transaction is outstanding, and feeds MEM/WB.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DMEM_ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EX_MEM_ALU_Result,
    input  logic [31:0] EX_MEM_PC_Plus4,
    input  logic [31:0] EX_MEM_Store_Data,
    input  logic [31:0] EX_MEM_Instr,
    output logic [31:0] MEM_ALU_Result,
    output logic [31:0] MEM_PC_Plus4,
    output logic [31:0] MEM_Read_Data,
    output logic [31:0] MEM_Instr,
    output logic        MEM_Stall,
    output logic        MEM_Fault,
    mem_stage_lsu_if.master dmem
);

    logic [6:0] opcode;
    logic [2:0] funct3_in;
    logic       is_load;
    logic       is_store;
    logic       is_ldst;
    logic       in_idle;
    logic       start;

    lsu_state_e state_reg, state_next;

    logic [DMEM_ADDR_W-1:0] addr_reg;
    logic                   we_reg;
    logic [31:0]            wdata_reg;
    logic [3:0]             wstrb_reg;
    logic [2:0]             funct3_reg;
    logic [1:0]             offset_reg;
    logic [31:0]            rdata_reg;

    logic        al_is_store;
    logic [2:0]  al_funct3;
    logic [1:0]  al_offset;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic        al_fault;
    logic [31:0] al_load_data;

    assign opcode    = EX_MEM_Instr[6:0];
    assign funct3_in = EX_MEM_Instr[14:12];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_ldst   = is_load || is_store;
    assign in_idle   = (state_reg == IDLE);

    // In IDLE the aligner looks at the live instruction; once a transaction
    // starts it works from the captured access so the response is decoded
    // against the request that produced it.
    assign al_is_store = in_idle ? is_store : we_reg;
    assign al_funct3   = in_idle ? funct3_in : funct3_reg;
    assign al_offset   = in_idle ? EX_MEM_ALU_Result[1:0] : offset_reg;

    mem_stage_lsu_align lsu_align (
        .is_store   (al_is_store),
        .funct3     (al_funct3),
        .offset     (al_offset),
        .store_data (EX_MEM_Store_Data),
        .rdata      (dmem.rsp_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .fault      (al_fault),
        .load_data  (al_load_data)
    );

    assign start = in_idle && is_ldst && !al_fault;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (dmem.req_ready) state_next = we_reg ? DONE : WAIT;
            WAIT:    if (dmem.rsp_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: request valid/strobes, stall and load result.
    always_comb begin
        dmem.req_valid = 1'b0;
        dmem.req_wstrb = 4'b0000;
        MEM_Stall      = 1'b0;
        MEM_Read_Data  = 32'h0;
        case (state_reg)
            IDLE: MEM_Stall = start;
            REQ: begin
                dmem.req_valid = 1'b1;
                dmem.req_wstrb = wstrb_reg;
                MEM_Stall      = 1'b1;
            end
            WAIT: MEM_Stall = 1'b1;
            DONE: MEM_Read_Data = we_reg ? 32'h0 : rdata_reg;
            default: ;
        endcase
    end

    // Capture the request fields when leaving IDLE so they stay stable in REQ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= 32'h0;
            wstrb_reg  <= 4'b0000;
            funct3_reg <= 3'b000;
            offset_reg <= 2'b00;
        end else if (start) begin
            addr_reg   <= {EX_MEM_ALU_Result[DMEM_ADDR_W-1:2], 2'b00};
            we_reg     <= is_store;
            wdata_reg  <= al_wdata;
            wstrb_reg  <= al_wstrb;
            funct3_reg <= funct3_in;
            offset_reg <= EX_MEM_ALU_Result[1:0];
        end
    end

    // Latch extended load data only for the response we are waiting for.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata_reg <= 32'h0;
        else if ((state_reg == WAIT) && dmem.rsp_valid)
            rdata_reg <= al_load_data;
    end

    assign dmem.req_we    = we_reg;
    assign dmem.req_addr  = addr_reg;
    assign dmem.req_wdata = wdata_reg;

    assign MEM_Fault      = is_ldst && al_fault;
    assign MEM_Instr      = MEM_Stall ? 32'h0 : EX_MEM_Instr;
    assign MEM_ALU_Result = MEM_Stall ? 32'h0 : EX_MEM_ALU_Result;
    assign MEM_PC_Plus4   = MEM_Stall ? 32'h0 : EX_MEM_PC_Plus4;

endmodule
